// File: rtl/pll_reset_sequencer.sv
// Gowin rPLL bring-up sequencer: pulses PLL RESET, qualifies LOCK on the reference
// clock, releases downstream resets one at a time and gives up after repeated lock timeouts.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3,
   parameter int NUM_DOMAINS         = 3,
   parameter int STAGE_GAP_CYCLES    = 8,
   localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   lock_i,
   output logic                   pll_reset_o,
   output logic [NUM_DOMAINS-1:0] rst_out_o,
   output logic                   ready_o,
   output logic                   fault_o,
   output logic [RTY_W-1:0]       retry_cnt_o,
   output logic [2:0]             state_o
);

   localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
   localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int GAP_W = $clog2(STAGE_GAP_CYCLES + 1);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE_CYCLES);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RELEASE   = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] w_sync_d;
   logic                   w_lock_s;
   logic [RST_W-1:0]       r_rst_cnt, w_rst_cnt_nxt;
   logic [STB_W-1:0]       r_stb_cnt, w_stb_nxt;
   logic [TMO_W-1:0]       r_tmo_cnt, w_tmo_nxt;
   logic [GAP_W-1:0]       r_gap_cnt, w_gap_nxt;
   logic [NUM_DOMAINS-1:0] r_rst_out, w_rst_out_nxt;
   logic [RTY_W-1:0]       r_retry, w_retry_nxt;
   logic                   r_pll_reset;
   logic                   r_ready;
   logic                   r_fault;

   generate
      if (SYNC_STAGES > 1) begin : g_sync_multi
         assign w_sync_d = {r_sync[SYNC_STAGES-2:0], lock_i};
      end else begin : g_sync_single
         assign w_sync_d = lock_i;
      end
   endgenerate

   assign w_lock_s = r_sync[SYNC_STAGES-1];

   // Lock synchroniser into the reference clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= w_sync_d;
      end
   end

   // Next-state, counter and reset-vector decode; each counter is cleared on entry to its state.
   always_comb begin
      w_state_nxt   = r_state;
      w_rst_cnt_nxt = r_rst_cnt;
      w_stb_nxt     = r_stb_cnt;
      w_tmo_nxt     = r_tmo_cnt;
      w_gap_nxt     = r_gap_cnt;
      w_rst_out_nxt = r_rst_out;
      w_retry_nxt   = r_retry;
      case (r_state)
         S_RESET_PLL: begin
            w_rst_out_nxt = '1;
            if (r_rst_cnt == RST_LAST) begin
               w_state_nxt = S_WAIT_LOCK;
               w_stb_nxt   = '0;
               w_tmo_nxt   = '0;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (w_lock_s) begin
               w_stb_nxt = r_stb_cnt + STB_W'(1);
            end else begin
               w_stb_nxt = '0;
            end
            w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
            // A lock that qualifies on the timeout cycle still counts as a success.
            if (w_stb_nxt == STB_MAX) begin
               w_state_nxt = S_RELEASE;
               w_gap_nxt   = '0;
            end else if (w_tmo_nxt == TMO_MAX) begin
               if (r_retry == RTY_MAX) begin
                  w_state_nxt = S_FAULT;
               end else begin
                  w_retry_nxt   = r_retry + RTY_W'(1);
                  w_state_nxt   = S_RESET_PLL;
                  w_rst_cnt_nxt = '0;
               end
            end else begin
               w_state_nxt = S_WAIT_LOCK;
            end
         end
         S_RELEASE: begin
            if (!w_lock_s) begin
               w_state_nxt   = S_RESET_PLL;
               w_rst_out_nxt = '1;
               w_rst_cnt_nxt = '0;
            end else if (r_rst_out == '0) begin
               w_state_nxt = S_RUN;
               w_retry_nxt = '0;
            end else if (r_gap_cnt == GAP_LAST) begin
               // Shifting a zero in from bit 0 releases domains strictly in index order.
               w_rst_out_nxt = r_rst_out << 1'b1;
               w_gap_nxt     = '0;
            end else begin
               w_gap_nxt = r_gap_cnt + GAP_W'(1);
            end
         end
         S_RUN: begin
            if (!w_lock_s) begin
               w_state_nxt   = S_RESET_PLL;
               w_rst_out_nxt = '1;
               w_rst_cnt_nxt = '0;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_FAULT: begin
            w_state_nxt   = S_FAULT;
            w_rst_out_nxt = '1;
         end
         default: begin
            w_state_nxt   = S_RESET_PLL;
            w_rst_out_nxt = '1;
            w_rst_cnt_nxt = '0;
         end
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_RESET_PLL;
         r_rst_cnt   <= '0;
         r_stb_cnt   <= '0;
         r_tmo_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_rst_out   <= '1;
         r_retry     <= '0;
         r_pll_reset <= 1'b1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rst_cnt   <= w_rst_cnt_nxt;
         r_stb_cnt   <= w_stb_nxt;
         r_tmo_cnt   <= w_tmo_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_rst_out   <= w_rst_out_nxt;
         r_retry     <= w_retry_nxt;
         r_pll_reset <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
         r_ready     <= (w_state_nxt == S_RUN);
         r_fault     <= (w_state_nxt == S_FAULT);
      end
   end

   assign pll_reset_o = r_pll_reset;
   assign rst_out_o   = r_rst_out;
   assign ready_o     = r_ready;
   assign fault_o     = r_fault;
   assign retry_cnt_o = r_retry;
   assign state_o     = r_state;

endmodule
